vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA/DVI raster timing generator.
- Successor to the fixed 640x480 sync block: every timing field is a parameter, as are sync polarities and the pixel clock-enable divide ratio.
- Adds a runtime enable, zero-skew registered outputs, line/frame start strobes and a frame counter.
- Sits between the system clock and the oscilloscope pixel renderer; x/y/video_on address the trace/graticule logic.

Parameters:
- CW, 10, width of the h/v counters and x/y outputs
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level (0 = active-low)
- PIX_DIV, 2, clk cycles per pixel (>=1)
- FCW, 16, frame counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  run enable; low freezes divider and counters
- pixel_tick  out  1  one-clk pixel strobe, every PIX_DIV clks while en=1
- hsync  out  1  horizontal sync at H_POL level during sync region
- vsync  out  1  vertical sync at V_POL level during sync region
- video_on  out  1  high when x<H_ACTIVE and y<V_ACTIVE
- x  out  CW  current horizontal count
- y  out  CW  current vertical count
- line_start  out  1  pixel_tick && x==0
- frame_start  out  1  pixel_tick && x==0 && y==0
- frame_cnt  out  FCW  completed frames, wraps at 2^FCW

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Elaboration error if either total exceeds 2^CW, PIX_DIV<1 or any sync width is 0.
- Line order: active, front porch, sync, back porch.
  - hsync region: h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync region: v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- Divider: div counts 0..PIX_DIV-1, wraps, advances only when en=1. pixel_tick = en && div==PIX_DIV-1 (combinational). For PIX_DIV=1, pixel_tick = en.
- h/v update only on clk edges where pixel_tick=1:
  - h wraps from H_TOTAL-1 to 0; otherwise h+1.
  - v advances only when h==H_TOTAL-1; wraps from V_TOTAL-1 to 0.
- Each (h,v) state is held exactly PIX_DIV clks when en is held high.
- hsync/vsync registers load the decode of the next h/v value every clk, so they are cycle-aligned with x/y (zero skew). video_on is a combinational decode of the current h/v.
- frame_cnt increments on the edge where h==H_TOTAL-1, v==V_TOTAL-1 and pixel_tick=1.
- Reset (reset=0, async):
  - div=0, h=0, v=0, frame_cnt=0
  - hsync=~H_POL, vsync=~V_POL (deasserted)
  - video_on=1, line_start/frame_start=0 until the first tick
- Reset mid-frame: all of the above is immediate. After release, the first frame_start occurs on clk PIX_DIV-1 (counting the first edge as 0), with en high.
- en low mid-line: all state frozen and every strobe is 0. Resuming continues from the exact div/h/v state, with no skipped or duplicated pixel.
- Simultaneous h and v wrap on a single tick: x=0, y=0 and frame_cnt+1 on the same edge.
- frame_cnt wraps silently at 2^FCW-1 to 0.

Decomposition:
- Shared package vga_pkg:
  - Timing constants for 640x480@60 (default), 800x600@60 and 1024x768@60.
  - A function returning the total count from active/fp/sync/bp.
  - Polarity constants SYNC_ACT_LOW/HIGH.
- One sub-module: vga_pix_div, the PIX_DIV clock-enable divider with en input and pixel_tick output, reused by the renderer.

Test Plan:
- Small params H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), PIX_DIV=2, release reset, en=1 -> each x held 2 clks; x sequence 0..13 then 0; hsync low exactly for x=10..12; vsync low for y=5..6; one frame = 224 clks; frame_cnt=1 after 224 clks.
- Same params, check video_on -> high only for x<8 && y<4; 32 active pixel-ticks per frame.
- PIX_DIV=1, H_POL=1 -> pixel_tick constant 1; hsync high for x=10..12, aligned on the same clk as x.
- Drop en for 5 clks at x=6, div=1 -> x, div and outputs frozen, strobes 0; after en returns x=7 follows after 1 clk.
- Assert reset at x=11, y=5 -> same instant hsync=1, vsync=1, x=y=0, frame_cnt=0; frame_start on clk 1 after release.
- FCW=2, run 5 frames -> frame_cnt 1,2,3,0,1; frame_start exactly once per 224 clks.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: standard mode tables, sync polarity
// constants and the line/frame total helper used by the generator and renderer.
package vga_pkg;

  localparam logic SYNC_ACT_LOW  = 1'b0;
  localparam logic SYNC_ACT_HIGH = 1'b1;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
    logic      h_pol;
    logic      v_pol;
  } vga_mode_t;

  localparam vga_mode_t VGA_640X480_60 = '{
    h:     '{active: 640, fp: 16, sync: 96, bp: 48},
    v:     '{active: 480, fp: 10, sync: 2, bp: 33},
    h_pol: SYNC_ACT_LOW,
    v_pol: SYNC_ACT_LOW
  };

  localparam vga_mode_t VGA_800X600_60 = '{
    h:     '{active: 800, fp: 40, sync: 128, bp: 88},
    v:     '{active: 600, fp: 1, sync: 4, bp: 23},
    h_pol: SYNC_ACT_HIGH,
    v_pol: SYNC_ACT_HIGH
  };

  localparam vga_mode_t VGA_1024X768_60 = '{
    h:     '{active: 1024, fp: 24, sync: 136, bp: 160},
    v:     '{active: 768, fp: 3, sync: 6, bp: 29},
    h_pol: SYNC_ACT_LOW,
    v_pol: SYNC_ACT_LOW
  };

  function automatic int unsigned vga_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel clock-enable divider: one-clk strobe every PIX_DIV enabled clocks.
// Shared with the renderer so both sides agree on pixel cadence.
module vga_pix_div #(
  parameter int PIX_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  generate
    if (PIX_DIV == 1) begin : g_bypass
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = i_clk ^ i_rst_n;
      assign o_tick           = i_en;
    end else begin : g_cnt
      localparam int DW = $clog2(PIX_DIV);

      logic [DW-1:0] r_div;
      logic          w_last;

      assign w_last = (r_div == DW'(PIX_DIV - 1));
      assign o_tick = i_en && w_last;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_div <= '0;
        end else if (i_en) begin
          r_div <= w_last ? '0 : r_div + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator with registered zero-skew
// syncs, line/frame strobes and a wrapping frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CW       = 10,
  parameter int   H_ACTIVE = VGA_640X480_60.h.active,
  parameter int   H_FP     = VGA_640X480_60.h.fp,
  parameter int   H_SYNC   = VGA_640X480_60.h.sync,
  parameter int   H_BP     = VGA_640X480_60.h.bp,
  parameter int   V_ACTIVE = VGA_640X480_60.v.active,
  parameter int   V_FP     = VGA_640X480_60.v.fp,
  parameter int   V_SYNC   = VGA_640X480_60.v.sync,
  parameter int   V_BP     = VGA_640X480_60.v.bp,
  parameter logic H_POL    = SYNC_ACT_LOW,
  parameter logic V_POL    = SYNC_ACT_LOW,
  parameter int   PIX_DIV  = 2,
  parameter int   FCW      = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  output logic           pixel_tick,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt
);

  localparam int H_TOTAL  = int'(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int V_TOTAL  = int'(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

  generate
    if (H_TOTAL > 2**CW) begin : g_bad_h_total
      $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > 2**CW) begin : g_bad_v_total
      $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end
    if (PIX_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: PIX_DIV must be at least 1");
    end
    if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
      $error("vga_timing_gen: sync widths must be non-zero");
    end
  endgenerate

  function automatic logic in_window(input logic [CW-1:0] c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) <= hi);
  endfunction

  logic           w_tick;
  logic           w_h_last;
  logic           w_v_last;
  logic [CW-1:0]  w_h_nxt;
  logic [CW-1:0]  w_v_nxt;
  logic [CW-1:0]  r_h;
  logic [CW-1:0]  r_v;
  logic           r_hsync;
  logic           r_vsync;
  logic [FCW-1:0] r_frame_cnt;

  vga_pix_div #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_div (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_en    (en),
    .o_tick  (w_tick)
  );

  assign w_h_last = (r_h == CW'(H_TOTAL - 1));
  assign w_v_last = (r_v == CW'(V_TOTAL - 1));

  always_comb begin
    w_h_nxt = r_h;
    w_v_nxt = r_v;
    if (w_tick) begin
      w_h_nxt = w_h_last ? '0 : r_h + 1'b1;
      if (w_h_last) begin
        w_v_nxt = w_v_last ? '0 : r_v + 1'b1;
      end
    end
  end

  // Syncs decode the next count so they change on the same edge as x/y.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h         <= '0;
      r_v         <= '0;
      r_hsync     <= ~H_POL;
      r_vsync     <= ~V_POL;
      r_frame_cnt <= '0;
    end else begin
      r_h     <= w_h_nxt;
      r_v     <= w_v_nxt;
      r_hsync <= in_window(w_h_nxt, HS_FIRST, HS_LAST) ? H_POL : ~H_POL;
      r_vsync <= in_window(w_v_nxt, VS_FIRST, VS_LAST) ? V_POL : ~V_POL;
      if (w_tick && w_h_last && w_v_last) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign pixel_tick  = w_tick;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign x           = r_h;
  assign y           = r_v;
  assign frame_cnt   = r_frame_cnt;
  assign video_on    = (r_h < CW'(H_ACTIVE)) && (r_v < CW'(V_ACTIVE));
  assign line_start  = w_tick && (r_h == '0);
  assign frame_start = w_tick && (r_h == '0) && (r_v == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 14x8 raster: PIX_DIV=2 active-low
// instance (FCW=2) and PIX_DIV=1 active-high-hsync instance side by side.
module tb_vga_timing_gen;

  localparam int CW = 4;

  logic clk;
  logic reset;
  logic en_a;
  logic en_b;

  logic          pixel_tick_a, hsync_a, vsync_a, video_on_a, line_start_a, frame_start_a;
  logic [CW-1:0] x_a, y_a;
  logic [1:0]    frame_cnt_a;

  logic          pixel_tick_b, hsync_b, vsync_b, video_on_b, line_start_b, frame_start_b;
  logic [CW-1:0] x_b, y_b;
  logic [15:0]   frame_cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  vga_timing_gen #(
    .CW(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .PIX_DIV(2), .FCW(2)
  ) dut_a (
    .clk(clk), .reset(reset), .en(en_a),
    .pixel_tick(pixel_tick_a), .hsync(hsync_a), .vsync(vsync_a),
    .video_on(video_on_a), .x(x_a), .y(y_a),
    .line_start(line_start_a), .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
  );

  vga_timing_gen #(
    .CW(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b0), .PIX_DIV(1), .FCW(16)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en_b),
    .pixel_tick(pixel_tick_b), .hsync(hsync_b), .vsync(vsync_b),
    .video_on(video_on_b), .x(x_b), .y(y_b),
    .line_start(line_start_b), .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "bench timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  int          fcnt_table [5] = '{1, 2, 3, 0, 1};
  int          fs_win;
  int          act_ticks;
  int          n, p, h, v;
  logic        tk;

  initial begin
    reset = 1'b0;
    en_a  = 1'b1;
    en_b  = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check_eq("rst_x", x_a, 0);
    check_eq("rst_y", y_a, 0);
    check_eq("rst_hsync", hsync_a, 1);
    check_eq("rst_vsync", vsync_a, 1);
    check_eq("rst_video_on", video_on_a, 1);
    check_eq("rst_line_start", line_start_a, 0);
    check_eq("rst_frame_start", frame_start_a, 0);
    check_eq("rst_frame_cnt", frame_cnt_a, 0);
    check_eq("rst_hsync_b", hsync_b, 0);

    reset     = 1'b1;
    fs_win    = 0;
    act_ticks = 0;

    // n = clock edges since release; p = pixels consumed
    for (int k = 0; k < 1282; k++) begin
      @(posedge clk);
      @(negedge clk);
      n  = k + 1;
      p  = n / 2;
      h  = p % 14;
      v  = (p / 14) % 8;
      tk = (n % 2) == 1;
      check_eq("a_x", x_a, h);
      check_eq("a_y", y_a, v);
      check_eq("a_tick", pixel_tick_a, tk);
      check_eq("a_hsync", hsync_a, (h >= 10 && h <= 12) ? 0 : 1);
      check_eq("a_vsync", vsync_a, (v >= 5 && v <= 6) ? 0 : 1);
      check_eq("a_video_on", video_on_a, (h < 8 && v < 4) ? 1 : 0);
      check_eq("a_line_start", line_start_a, (tk && h == 0) ? 1 : 0);
      check_eq("a_frame_start", frame_start_a, (tk && h == 0 && v == 0) ? 1 : 0);
      check_eq("a_frame_cnt", frame_cnt_a, (p / 112) % 4);

      h = n % 14;
      v = (n / 14) % 8;
      check_eq("b_tick", pixel_tick_b, 1);
      check_eq("b_x", x_b, h);
      check_eq("b_y", y_b, v);
      check_eq("b_hsync", hsync_b, (h >= 10 && h <= 12) ? 1 : 0);
      check_eq("b_vsync", vsync_b, (v >= 5 && v <= 6) ? 0 : 1);
      check_eq("b_frame_cnt", frame_cnt_b, n / 112);

      if (frame_start_a) fs_win++;
      if (n <= 224 && pixel_tick_a && video_on_a) act_ticks++;
      if (n == 223) check_eq("fcnt_before_224", frame_cnt_a, 0);
      if (n == 224) check_eq("active_ticks_frame0", act_ticks, 32);
      if (n % 224 == 0 && n <= 1120) begin
        check_eq("frame_start_per_224", fs_win, 1);
        check_eq("fcnt_seq", frame_cnt_a, fcnt_table[n / 224 - 1]);
        fs_win = 0;
      end
    end

    // mid-frame reset at x=11, y=5
    check_eq("pre_rst_x", x_a, 11);
    check_eq("pre_rst_y", y_a, 5);
    check_eq("pre_rst_hsync", hsync_a, 0);
    check_eq("pre_rst_vsync", vsync_a, 0);
    check_eq("pre_rst_fcnt", frame_cnt_a, 1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_hsync", hsync_a, 1);
    check_eq("mid_rst_vsync", vsync_a, 1);
    check_eq("mid_rst_x", x_a, 0);
    check_eq("mid_rst_y", y_a, 0);
    check_eq("mid_rst_fcnt", frame_cnt_a, 0);
    check_eq("mid_rst_video_on", video_on_a, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rel_frame_start_pre", frame_start_a, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("rel_frame_start_clk1", frame_start_a, 1);
    check_eq("rel_x", x_a, 0);

    // walk to x=6 with div=1, then pause
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("pause_x", x_a, 6);
    check_eq("pause_tick_before", pixel_tick_a, 1);
    en_a = 1'b0;
    #1;
    check_eq("pause_tick_off", pixel_tick_a, 0);
    check_eq("pause_line_start", line_start_a, 0);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("frozen_x", x_a, 6);
      check_eq("frozen_y", y_a, 0);
      check_eq("frozen_tick", pixel_tick_a, 0);
      check_eq("frozen_hsync", hsync_a, 1);
      check_eq("frozen_video_on", video_on_a, 1);
      check_eq("frozen_frame_start", frame_start_a, 0);
    end
    en_a = 1'b1;
    #1;
    check_eq("resume_tick", pixel_tick_a, 1);
    check_eq("resume_x_hold", x_a, 6);
    @(posedge clk);
    @(negedge clk);
    check_eq("resume_x7", x_a, 7);
    check_eq("resume_tick_div0", pixel_tick_a, 0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("resume_x8", x_a, 8);
    check_eq("resume_video_off", video_on_a, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
